rgmii2gmii_rx: RTL
==================

# rgmii2gmii_rx

Receive-side RGMII-to-GMII converter for the OpenCore MAC gigabit path. It captures the double-data-rate RGMII receive nibbles and control from the PHY and rebuilds a single-data-rate GMII byte stream with RxDv and RxErr. It also tracks frame boundaries (preamble/SFD, end of frame, error), counts good and errored frames, and decodes RGMII in-band link status. It sits between the PHY pins and the MAC receive engine, mirroring the transmit-side GMII-to-RGMII converter.

## Interface
Parameters:
- MAX_PRE, 7: maximum preamble bytes (0x55) accepted before SFD; exceeding it is a preamble error.
- CNT_W, 16: width of frame counters.

Ports (name, direction, width, meaning):
- RxClk, in, 1: RGMII receive clock from the PHY, 125 MHz. Both edges are used, inside the DDR sub-module only.
- rst_n, in, 1: asynchronous, active-low reset.
- RGMII_RxD, in, 4: DDR data. The rising edge carries bits [3:0]; the falling edge carries bits [7:4].
- RGMII_RxCtl, in, 1: DDR control. The rising edge carries RX_DV; the falling edge carries RX_DV xor RX_ER.
- ClkEN, in, 1: capture enable. When 0, the GMII outputs hold their last values and the FSM is frozen.
- CntClr, in, 1: synchronous clear of both frame counters.
- RxD, out, 8: GMII data.
- RxDv, out, 1: GMII data valid.
- RxErr, out, 1: GMII receive error.
- RxSof, out, 1: one-cycle pulse with the first byte after SFD.
- RxEof, out, 1: one-cycle pulse in the first cycle RxDv is 0 after a frame.
- FrameErr, out, 1: valid with RxEof; 1 if the frame had any error.
- GoodFrames, out, CNT_W: saturating count of frames ending without error.
- ErrFrames, out, CNT_W: saturating count of frames ending with error.
- LinkUp, out, 1: in-band link status.
- Speed, out, 2: in-band speed (00 = 10M, 01 = 100M, 10 = 1000M).
- FullDuplex, out, 1: in-band duplex.

## Operation
- DDR capture:
  - The sub-module presents the rise pair {ctl_h, d_h} and the fall pair {ctl_l, d_l} of the same RxClk period, aligned to posedge.
  - Decode: RxDv = ctl_h; RxErr = ctl_h ^ ctl_l; RxD = {d_l, d_h}. All three are registered.
- Frame FSM states: IDLE, PRE, DATA, DROP.
  - IDLE → PRE when RxDv=1 and RxD=0x55.
  - IDLE → DATA when RxDv=1 and RxD=0xD5 (zero-preamble SFD).
  - IDLE → DROP when RxDv=1 with any other byte.
  - PRE, on each 0x55 byte: increment the preamble count. When the count exceeds MAX_PRE, → DROP.
  - PRE → DATA on 0xD5.
  - PRE → DROP on any other byte.
  - DATA: RxSof is asserted with the first byte after SFD. Any RxErr=1 sets a sticky error flag.
  - DATA or DROP → IDLE when RxDv falls. RxEof pulses, and FrameErr = sticky flag, or 1 if the state was DROP.
- Errored frames: a frame counts as errored if it ended in DROP or carried RxErr.
- RxDv=0 with RxErr=1 (carrier extend 0x0F, false carrier 0x0E):
  - Outside a frame: passed through on the GMII outputs; no FSM effect.
  - Inside DATA: terminates the frame like a falling RxDv.
- Counters:
  - On RxEof, increment GoodFrames or ErrFrames. Each saturates at all-ones.
  - CntClr has priority over an increment in the same cycle.
- Reset values:
  - RxD=0x00.
  - RxDv, RxErr, RxSof, RxEof, FrameErr = 0.
  - Both counters 0.
  - LinkUp=0, Speed=2'b00, FullDuplex=0.
  - FSM = IDLE.
- Reset asserted mid-frame: everything returns to reset values immediately. No RxEof is issued, and no counter is updated.

## Timing
- Latency from the rising edge carrying the low nibble to the GMII outputs: 2 RxClk posedges (1 in the DDR sub-module, 1 output register).
- RxSof, RxEof and FrameErr are registered in the same stage as RxD, so they line up with the byte they describe.
- Back-to-back frames with a 1-cycle gap: RxEof for frame N and the IDLE → PRE transition for frame N+1 happen on consecutive cycles. Both frames are counted.
- ClkEN=0: the capture registers, FSM and counters hold. Pulses are not repeated while ClkEN=0.

## Configuration
- RGMII_RX_INBAND_STATUS_EN defined:
  - In IDLE, when RxDv=0 and RxErr=0, decode RxD[3:0]: bit0 = link, bits[2:1] = speed, bit3 = duplex.
  - LinkUp, Speed and FullDuplex update only after the same nibble has been seen on 2 consecutive cycles.
- Undefined: LinkUp=1, Speed=2'b10 and FullDuplex=1 as constants once reset is released. No decode logic is built.

## Structure
- Shared package holds:
  - Localparams SFD_BYTE=8'hD5, PRE_BYTE=8'h55, CARRIER_EXT=8'h0F, FALSE_CARRIER=8'h0E.
  - The FSM state encoding.
  - The speed encodings.
- Sub-module rgmii_ddr_in: wraps the vendor DDR input primitive. It produces the 5-bit rise and fall words re-registered on posedge RxClk, and is the only logic that uses the negedge.

## Test plan
- Normal frame: 7×0x55, 0xD5, then 64 bytes 0x00..0x3F → RxSof with 0x00, RxEof after 0x3F, FrameErr=0, GoodFrames=1.
- Error inside a frame: RxErr=1 on byte 10 of a 64-byte frame → FrameErr=1 with RxEof, ErrFrames=1, GoodFrames unchanged.
- Bad preamble: 9×0x55 then 0xD5 with MAX_PRE=7 → DROP, no RxSof, ErrFrames increments.
- In-band status (with RGMII_RX_INBAND_STATUS_EN): idle nibble 0xD for 2 cycles → LinkUp=1, Speed=10, FullDuplex=1. A single-cycle 0x0 glitch leaves them unchanged.
- Counter saturation and clear: preload by running 2^CNT_W good frames → GoodFrames holds 0xFFFF. CntClr in the same cycle as RxEof → GoodFrames=0.
- Reset mid-frame: rst_n low during byte 20 → all outputs at reset values, no RxEof. The next full frame is counted normally.

Source files
------------

// File: rtl/rgmii2gmii_rx_pkg.sv
// Shared constants for the RGMII receive converter: framing bytes, FSM state
// encoding and in-band speed codes.
package rgmii2gmii_rx_pkg;

  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] PRE_BYTE      = 8'h55;
  localparam logic [7:0] CARRIER_EXT   = 8'h0F;
  localparam logic [7:0] FALSE_CARRIER = 8'h0E;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_PRE  = 2'd1;
  localparam fsm_state_t ST_DATA = 2'd2;
  localparam fsm_state_t ST_DROP = 2'd3;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  // One DDR half-period sample: control bit over the data nibble.
  typedef struct packed {
    logic       ctl;
    logic [3:0] d;
  } ddr_word_t;

endpackage

// File: rtl/rgmii2gmii_rx_ddr_in.sv
// DDR input capture for RGMII receive: samples rise and fall words and presents
// the pair of one RxClk period aligned to posedge. Only logic using the negedge.
module rgmii_ddr_in (
  input  logic       RxClk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [3:0] i_d,
  input  logic       i_ctl,
  output logic [4:0] o_rise,
  output logic [4:0] o_fall
);

  logic [4:0] r_rise_cap;
  logic [4:0] r_fall_cap;
  logic [4:0] r_rise;
  logic [4:0] r_fall;

  always_ff @(negedge RxClk or negedge rst_n) begin
    if (!rst_n) r_fall_cap <= '0;
    else        r_fall_cap <= {i_ctl, i_d};
  end

  // The fall word sampled half a period after r_rise_cap belongs to the same
  // period, so both are re-registered together on the following posedge.
  always_ff @(posedge RxClk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise_cap <= '0;
      r_rise     <= '0;
      r_fall     <= '0;
    end else if (i_en) begin
      r_rise_cap <= {i_ctl, i_d};
      r_rise     <= r_rise_cap;
      r_fall     <= r_fall_cap;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/rgmii2gmii_rx.sv
// RGMII-to-GMII receive converter with frame tracking and frame counters.
// Define RGMII_RX_INBAND_STATUS_EN to decode in-band link status from idle nibbles.
module rgmii2gmii_rx
  import rgmii2gmii_rx_pkg::*;
#(
  parameter int MAX_PRE = 7,
  parameter int CNT_W   = 16
) (
  input  logic             RxClk,
  input  logic             rst_n,
  input  logic [3:0]       RGMII_RxD,
  input  logic             RGMII_RxCtl,
  input  logic             ClkEN,
  input  logic             CntClr,
  output logic [7:0]       RxD,
  output logic             RxDv,
  output logic             RxErr,
  output logic             RxSof,
  output logic             RxEof,
  output logic             FrameErr,
  output logic [CNT_W-1:0] GoodFrames,
  output logic [CNT_W-1:0] ErrFrames,
  output logic             LinkUp,
  output logic [1:0]       Speed,
  output logic             FullDuplex
);

  localparam int PRE_W = $clog2(MAX_PRE + 2);

  ddr_word_t  w_rise;
  ddr_word_t  w_fall;
  logic       w_dv;
  logic       w_er;
  logic [7:0] w_d;

  rgmii_ddr_in u_ddr (
    .RxClk  (RxClk),
    .rst_n  (rst_n),
    .i_en   (ClkEN),
    .i_d    (RGMII_RxD),
    .i_ctl  (RGMII_RxCtl),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_dv = w_rise.ctl;
  assign w_er = w_rise.ctl ^ w_fall.ctl;
  assign w_d  = {w_fall.d, w_rise.d};

  fsm_state_t       r_state;
  fsm_state_t       w_state_next;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [PRE_W-1:0] w_pre_next;
  logic [PRE_W-1:0] w_pre_inc;
  logic             r_sof_pend;
  logic             w_pend_next;
  logic             r_sticky;
  logic             w_sticky_next;
  logic             w_sof;
  logic             w_eof;
  logic             w_ferr;

  assign w_pre_inc = r_pre_cnt + PRE_W'(1);

  always_comb begin
    w_state_next  = r_state;
    w_pre_next    = r_pre_cnt;
    w_pend_next   = r_sof_pend;
    w_sticky_next = r_sticky;
    w_sof         = 1'b0;
    w_eof         = 1'b0;
    w_ferr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_dv) begin
          w_sticky_next = 1'b0;
          w_pend_next   = 1'b0;
          if (w_d == PRE_BYTE) begin
            w_state_next = ST_PRE;
            w_pre_next   = PRE_W'(1);
          end else if (w_d == SFD_BYTE) begin
            w_state_next = ST_DATA;
            w_pend_next  = 1'b1;
          end else begin
            w_state_next = ST_DROP;
          end
        end
      end
      ST_PRE: begin
        // A preamble cut short by falling RxDv is reported as an errored frame.
        if (!w_dv) begin
          w_state_next = ST_IDLE;
          w_eof        = 1'b1;
          w_ferr       = 1'b1;
        end else if (w_d == PRE_BYTE) begin
          if (w_pre_inc > PRE_W'(MAX_PRE)) w_state_next = ST_DROP;
          else                             w_pre_next   = w_pre_inc;
        end else if (w_d == SFD_BYTE) begin
          w_state_next = ST_DATA;
          w_pend_next  = 1'b1;
        end else begin
          w_state_next = ST_DROP;
        end
      end
      ST_DATA: begin
        // RxDv low covers both a plain end of frame and carrier extension.
        if (!w_dv) begin
          w_state_next = ST_IDLE;
          w_eof        = 1'b1;
          w_ferr       = r_sticky;
        end else begin
          w_sof       = r_sof_pend;
          w_pend_next = 1'b0;
          if (w_er) w_sticky_next = 1'b1;
        end
      end
      default: begin
        if (!w_dv) begin
          w_state_next = ST_IDLE;
          w_eof        = 1'b1;
          w_ferr       = 1'b1;
        end
      end
    endcase
  end

  logic [7:0] r_rxd;
  logic       r_rxdv;
  logic       r_rxerr;
  logic       r_sof;
  logic       r_eof;
  logic       r_ferr;

  always_ff @(posedge RxClk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pre_cnt  <= '0;
      r_sof_pend <= 1'b0;
      r_sticky   <= 1'b0;
      r_rxd      <= 8'h00;
      r_rxdv     <= 1'b0;
      r_rxerr    <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_ferr     <= 1'b0;
    end else if (ClkEN) begin
      r_state    <= w_state_next;
      r_pre_cnt  <= w_pre_next;
      r_sof_pend <= w_pend_next;
      r_sticky   <= w_sticky_next;
      r_rxd      <= w_d;
      r_rxdv     <= w_dv;
      r_rxerr    <= w_er;
      r_sof      <= w_sof;
      r_eof      <= w_eof;
      r_ferr     <= w_ferr;
    end else begin
      r_sof <= 1'b0;
      r_eof <= 1'b0;
    end
  end

  logic [CNT_W-1:0] r_good;
  logic [CNT_W-1:0] r_err;

  always_ff @(posedge RxClk or negedge rst_n) begin
    if (!rst_n) begin
      r_good <= '0;
      r_err  <= '0;
    end else if (CntClr) begin
      r_good <= '0;
      r_err  <= '0;
    end else if (ClkEN && w_eof) begin
      if (w_ferr) begin
        if (r_err != '1) r_err <= r_err + CNT_W'(1);
      end else begin
        if (r_good != '1) r_good <= r_good + CNT_W'(1);
      end
    end
  end

  logic       r_link;
  logic [1:0] r_speed;
  logic       r_fd;

`ifdef RGMII_RX_INBAND_STATUS_EN
  logic [3:0] r_ib_prev;
  logic       r_ib_valid;
  logic       w_ib_sample;

  assign w_ib_sample = (r_state == ST_IDLE) && !w_dv && !w_er;

  // Status only moves once the same idle nibble has been seen twice in a row.
  always_ff @(posedge RxClk or negedge rst_n) begin
    if (!rst_n) begin
      r_ib_prev  <= 4'h0;
      r_ib_valid <= 1'b0;
      r_link     <= 1'b0;
      r_speed    <= SPEED_10;
      r_fd       <= 1'b0;
    end else if (ClkEN) begin
      if (w_ib_sample) begin
        r_ib_prev  <= w_d[3:0];
        r_ib_valid <= 1'b1;
        if (r_ib_valid && (r_ib_prev == w_d[3:0])) begin
          r_link  <= w_d[0];
          r_speed <= w_d[2:1];
          r_fd    <= w_d[3];
        end
      end else begin
        r_ib_valid <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge RxClk or negedge rst_n) begin
    if (!rst_n) begin
      r_link  <= 1'b0;
      r_speed <= SPEED_10;
      r_fd    <= 1'b0;
    end else begin
      r_link  <= 1'b1;
      r_speed <= SPEED_1000;
      r_fd    <= 1'b1;
    end
  end
`endif

  assign RxD        = r_rxd;
  assign RxDv       = r_rxdv;
  assign RxErr      = r_rxerr;
  assign RxSof      = r_sof;
  assign RxEof      = r_eof;
  assign FrameErr   = r_ferr;
  assign GoodFrames = r_good;
  assign ErrFrames  = r_err;
  assign LinkUp     = r_link;
  assign Speed      = r_speed;
  assign FullDuplex = r_fd;

endmodule
